// File: rtl/gb_timer_pkg.sv
// ============================================================================
// Module   : gb_timer_pkg
// Purpose  : Shared constants, tap-select table and FSM state type for the
//            Game Boy DIV/TIMA timer. Build option: GB_TIMER_RELOAD_DELAY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gb_timer_pkg;

  localparam logic [15:0] ADDR_DIV  = 16'hFF04;
  localparam logic [15:0] ADDR_TIMA = 16'hFF05;
  localparam logic [15:0] ADDR_TMA  = 16'hFF06;
  localparam logic [15:0] ADDR_TAC  = 16'hFF07;

  localparam int TAC_EN_BIT   = 2;
  localparam int TAC_RATE_MSB = 1;
  localparam int TAC_RATE_LSB = 0;

  // Divider bit watched for each TAC rate select value
  localparam int TAP_BIT_00 = 9;
  localparam int TAP_BIT_01 = 3;
  localparam int TAP_BIT_10 = 5;
  localparam int TAP_BIT_11 = 7;

`ifdef GB_TIMER_RELOAD_DELAY_EN
  typedef enum logic [0:0] {
    ST_COUNT  = 1'b0,
    ST_RELOAD = 1'b1
  } timer_state_e;
`else
  typedef enum logic [0:0] {
    ST_COUNT  = 1'b0
  } timer_state_e;
`endif

  // taps[n] holds the divider bit selected by rate code n
  function automatic logic tap_select(input logic [3:0] taps, input logic [1:0] sel);
    tap_select = taps[sel];
  endfunction

endpackage

`default_nettype wire

// File: rtl/gb_timer_if.sv
// ============================================================================
// Module   : gb_timer_if
// Purpose  : io-register side bundle between the FF04-FF07 registers and the
//            timer core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gb_timer_if;
  logic       I_DIV_DBUS_WRITE;
  logic [7:0] I_TIMA;
  logic       I_TIMA_DBUS_WRITE;
  logic       I_TIMA_WAIT;
  logic [7:0] I_TMA;
  logic [2:0] I_TAC;
  logic [7:0] O_DIV_DATA;
  logic       O_DIV_WR_EN;
  logic [7:0] O_TIMA_DATA;
  logic       O_TIMA_WR_EN;
  logic       O_TIMER_IRQ;

  modport master (
    output I_DIV_DBUS_WRITE, I_TIMA, I_TIMA_DBUS_WRITE, I_TIMA_WAIT, I_TMA, I_TAC,
    input  O_DIV_DATA, O_DIV_WR_EN, O_TIMA_DATA, O_TIMA_WR_EN, O_TIMER_IRQ
  );

  modport slave (
    input  I_DIV_DBUS_WRITE, I_TIMA, I_TIMA_DBUS_WRITE, I_TIMA_WAIT, I_TMA, I_TAC,
    output O_DIV_DATA, O_DIV_WR_EN, O_TIMA_DATA, O_TIMA_WR_EN, O_TIMER_IRQ
  );
endinterface

`default_nettype wire

// File: rtl/gb_timer_div.sv
// ============================================================================
// Module   : gb_timer_div
// Purpose  : 16-bit free-running divider, TAC tap mux and falling-edge
//            detector producing the TIMA increment request and DIV strobe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gb_timer_div
  import gb_timer_pkg::*;
#(
  parameter logic [15:0] P_DIV_RST_VAL = 16'h0000
) (
  input  wire logic       I_CLK,
  input  wire logic       I_RESET_L,
  input  wire logic       i_div_clear,
  input  wire logic [2:0] i_tac,
  output logic      [7:0] o_div_data,
  output logic            o_div_wr_en,
  output logic            o_inc_req
);

  logic [15:0] div_q,    div_d;
  logic        div_wr_q, div_wr_d;
  logic        tick_q,   tick_d;

  always_comb begin
    div_d    = i_div_clear ? 16'h0000 : div_q + 16'd1;
    div_wr_d = (div_d[15:8] != div_q[15:8]);
    // tick_d is the live tick; tick_q remembers it for the falling-edge test
    tick_d   = i_tac[TAC_EN_BIT] &
               tap_select({div_q[TAP_BIT_11], div_q[TAP_BIT_10],
                           div_q[TAP_BIT_01], div_q[TAP_BIT_00]},
                          i_tac[TAC_RATE_MSB:TAC_RATE_LSB]);
  end

  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      div_q    <= P_DIV_RST_VAL;
      div_wr_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      div_q    <= div_d;
      div_wr_q <= div_wr_d;
      tick_q   <= tick_d;
    end
  end

  assign o_div_data  = div_q[15:8];
  assign o_div_wr_en = div_wr_q;
  assign o_inc_req   = tick_q & ~tick_d;

endmodule

`default_nettype wire

// File: rtl/gb_timer.sv
// ============================================================================
// Module   : gb_timer
// Purpose  : Game Boy DIV/TIMA/TMA/TAC timer core. Define
//            GB_TIMER_RELOAD_DELAY_EN for the delayed TMA reload behaviour.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gb_timer
  import gb_timer_pkg::*;
#(
  parameter logic [15:0] P_DIV_RST_VAL  = 16'h0000,
  parameter int          P_RELOAD_DELAY = 4
) (
  input wire logic I_CLK,
  input wire logic I_RESET_L,
  gb_timer_if.slave bus
);

  generate
    if (P_RELOAD_DELAY < 1 || P_RELOAD_DELAY > 7) begin : g_bad_reload_delay
      $error("gb_timer: P_RELOAD_DELAY must be within 1..7");
    end
  endgenerate

  logic       inc_req;
  logic [7:0] div_data;
  logic       div_wr_en;

  gb_timer_div #(
    .P_DIV_RST_VAL (P_DIV_RST_VAL)
  ) u_div (
    .I_CLK       (I_CLK),
    .I_RESET_L   (I_RESET_L),
    .i_div_clear (bus.I_DIV_DBUS_WRITE),
    .i_tac       (bus.I_TAC),
    .o_div_data  (div_data),
    .o_div_wr_en (div_wr_en),
    .o_inc_req   (inc_req)
  );

  timer_state_e state_q,     state_d;
  logic [7:0]   tima_data_q, tima_data_d;
  logic         tima_wr_q,   tima_wr_d;
  logic         irq_q,       irq_d;

`ifdef GB_TIMER_RELOAD_DELAY_EN
  localparam logic [2:0] RELOAD_CNT = 3'(P_RELOAD_DELAY);
  logic [2:0] cnt_q, cnt_d;
`else
  logic unused_tima_dbus_write;
  assign unused_tima_dbus_write = bus.I_TIMA_DBUS_WRITE;
`endif

  always_comb begin
    state_d     = state_q;
    tima_data_d = tima_data_q;
    tima_wr_d   = 1'b0;
    irq_d       = 1'b0;
`ifdef GB_TIMER_RELOAD_DELAY_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      ST_COUNT: begin
        // A CPU write to TIMA in the same cycle beats the timer increment
        if (inc_req && !bus.I_TIMA_WAIT) begin
          tima_wr_d = 1'b1;
          if (bus.I_TIMA != 8'hFF) begin
            tima_data_d = bus.I_TIMA + 8'd1;
          end else begin
`ifdef GB_TIMER_RELOAD_DELAY_EN
            tima_data_d = 8'h00;
            state_d     = ST_RELOAD;
            cnt_d       = RELOAD_CNT;
`else
            tima_data_d = bus.I_TMA;
            irq_d       = 1'b1;
`endif
          end
        end
      end
`ifdef GB_TIMER_RELOAD_DELAY_EN
      ST_RELOAD: begin
        if (bus.I_TIMA_DBUS_WRITE) begin
          state_d = ST_COUNT;
          cnt_d   = 3'd0;
        end else if (cnt_q == 3'd1) begin
          tima_data_d = bus.I_TMA;
          tima_wr_d   = 1'b1;
          irq_d       = 1'b1;
          state_d     = ST_COUNT;
          cnt_d       = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
`endif
      default: state_d = ST_COUNT;
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      state_q     <= ST_COUNT;
      tima_data_q <= 8'h00;
      tima_wr_q   <= 1'b0;
      irq_q       <= 1'b0;
`ifdef GB_TIMER_RELOAD_DELAY_EN
      cnt_q       <= 3'd0;
`endif
    end else begin
      state_q     <= state_d;
      tima_data_q <= tima_data_d;
      tima_wr_q   <= tima_wr_d;
      irq_q       <= irq_d;
`ifdef GB_TIMER_RELOAD_DELAY_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bus.O_DIV_DATA   = div_data;
  assign bus.O_DIV_WR_EN  = div_wr_en;
  assign bus.O_TIMA_DATA  = tima_data_q;
  assign bus.O_TIMA_WR_EN = tima_wr_q;
  assign bus.O_TIMER_IRQ  = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_gb_timer.sv
// ============================================================================
// Module   : tb_gb_timer
// Purpose  : Directed self-checking bench for gb_timer (both build options).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gb_timer;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  gb_timer_if tif();

  gb_timer #(
    .P_DIV_RST_VAL  (16'h0000),
    .P_RELOAD_DELAY (4)
  ) dut (
    .I_CLK     (clk),
    .I_RESET_L (rst_n),
    .bus       (tif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tima_wr(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      step();
      seen = tif.O_TIMA_WR_EN;
    end
    check(tag, 16'(seen), 16'd1);
  endtask

  task automatic count_pulses(input int n, output int wr, output int irq);
    wr  = 0;
    irq = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (tif.O_TIMA_WR_EN) wr++;
      if (tif.O_TIMER_IRQ)  irq++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int first, second, wr_cnt, irq_cnt;
    logic [7:0] first_data;

    rst_n                 = 1'b0;
    tif.I_DIV_DBUS_WRITE  = 1'b0;
    tif.I_TIMA            = 8'h00;
    tif.I_TIMA_DBUS_WRITE = 1'b0;
    tif.I_TIMA_WAIT       = 1'b0;
    tif.I_TMA             = 8'h00;
    tif.I_TAC             = 3'b000;
    step();
    step();

    // Held in reset
    check("rst_div_data",  16'(tif.O_DIV_DATA),   16'h00);
    check("rst_div_wr",    16'(tif.O_DIV_WR_EN),  16'h0);
    check("rst_tima_data", 16'(tif.O_TIMA_DATA),  16'h00);
    check("rst_tima_wr",   16'(tif.O_TIMA_WR_EN), 16'h0);
    check("rst_irq",       16'(tif.O_TIMER_IRQ),  16'h0);

    // Release with TAC=101: tap divider[3], falls every 16 cycles
    tif.I_TAC = 3'b101;
    rst_n     = 1'b1;
    first     = 0;
    second    = 0;
    first_data = 8'h00;
    for (int k = 1; k <= 255; k++) begin
      step();
      if (tif.O_TIMA_WR_EN) begin
        if (first == 0) begin
          first      = k;
          first_data = tif.O_TIMA_DATA;
        end else if (second == 0) begin
          second = k;
        end
      end
    end
    check("first_inc_cycle", 16'(first), 16'd17);
    check("inc_period",      16'(second - first), 16'd16);
    check("first_inc_data",  16'(first_data), 16'h01);
    step();
    check("div_strobe_256", 16'(tif.O_DIV_WR_EN), 16'h1);
    check("div_data_256",   16'(tif.O_DIV_DATA),  16'h01);
    step();
    check("div_strobe_257", 16'(tif.O_DIV_WR_EN),  16'h0);
    check("inc_257",        16'(tif.O_TIMA_WR_EN), 16'h1);

    // Overflow
    tif.I_TIMA = 8'hFF;
    tif.I_TMA  = 8'hA0;
    wait_tima_wr("ovf_timeout");
`ifdef GB_TIMER_RELOAD_DELAY_EN
    check("ovf_data_zero", 16'(tif.O_TIMA_DATA), 16'h00);
    check("ovf_irq_early", 16'(tif.O_TIMER_IRQ), 16'h0);
    count_pulses(3, wr_cnt, irq_cnt);
    check("reload_quiet", 16'(wr_cnt + irq_cnt), 16'd0);
    step();
    check("reload_wr",   16'(tif.O_TIMA_WR_EN), 16'h1);
    check("reload_data", 16'(tif.O_TIMA_DATA),  16'hA0);
    check("reload_irq",  16'(tif.O_TIMER_IRQ),  16'h1);
    step();
    check("reload_irq_clear", 16'(tif.O_TIMER_IRQ), 16'h0);

    // CPU write during the reload window cancels it
    wait_tima_wr("cancel_ovf_timeout");
    check("cancel_ovf_data", 16'(tif.O_TIMA_DATA), 16'h00);
    step();
    tif.I_TIMA_DBUS_WRITE = 1'b1;
    tif.I_TIMA_WAIT       = 1'b1;
    step();
    tif.I_TIMA_DBUS_WRITE = 1'b0;
    tif.I_TIMA_WAIT       = 1'b0;
    count_pulses(6, wr_cnt, irq_cnt);
    check("cancel_no_wr",  16'(wr_cnt),  16'd0);
    check("cancel_no_irq", 16'(irq_cnt), 16'd0);
`else
    check("ovf_data_tma", 16'(tif.O_TIMA_DATA), 16'hA0);
    check("ovf_irq",      16'(tif.O_TIMER_IRQ), 16'h1);
    step();
    check("ovf_irq_clear", 16'(tif.O_TIMER_IRQ), 16'h0);
`endif

    // Increment colliding with a CPU TIMA write is dropped
    tif.I_TIMA = 8'h10;
    wait_tima_wr("wait_sync_timeout");
    for (int i = 0; i < 15; i++) step();
    tif.I_TIMA_WAIT = 1'b1;
    step();
    check("wait_drops_inc", 16'(tif.O_TIMA_WR_EN), 16'h0);
    tif.I_TIMA_WAIT = 1'b0;
    for (int i = 0; i < 16; i++) step();
    check("inc_after_wait",      16'(tif.O_TIMA_WR_EN), 16'h1);
    check("inc_after_wait_data", 16'(tif.O_TIMA_DATA),  16'h11);

    // DIV clear strobe, then a clear while divider[9]=1 with TAC=100
    tif.I_TAC            = 3'b000;
    tif.I_TIMA           = 8'h20;
    tif.I_DIV_DBUS_WRITE = 1'b1;
    step();
    tif.I_DIV_DBUS_WRITE = 1'b0;
    check("div_clr_data",   16'(tif.O_DIV_DATA),  16'h00);
    check("div_clr_strobe", 16'(tif.O_DIV_WR_EN), 16'h1);
    tif.I_TAC = 3'b100;
    count_pulses(600, wr_cnt, irq_cnt);
    check("div9_rise_no_inc", 16'(wr_cnt), 16'd0);
    check("div_data_600",     16'(tif.O_DIV_DATA), 16'h02);
    tif.I_DIV_DBUS_WRITE = 1'b1;
    step();
    tif.I_DIV_DBUS_WRITE = 1'b0;
    check("div_clr2_data",   16'(tif.O_DIV_DATA),  16'h00);
    check("div_clr2_strobe", 16'(tif.O_DIV_WR_EN), 16'h1);
    step();
    check("div_clr_inc_wr",   16'(tif.O_TIMA_WR_EN), 16'h1);
    check("div_clr_inc_data", 16'(tif.O_TIMA_DATA),  16'h21);
    count_pulses(50, wr_cnt, irq_cnt);
    check("div_clr_single_inc", 16'(wr_cnt), 16'd0);

    // Reset shortly after an overflow: outputs clear, no IRQ follows
    tif.I_TAC  = 3'b101;
    tif.I_TIMA = 8'hFF;
    tif.I_TMA  = 8'hA0;
    wait_tima_wr("rst_ovf_timeout");
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_div_data",  16'(tif.O_DIV_DATA),   16'h00);
    check("midrst_div_wr",    16'(tif.O_DIV_WR_EN),  16'h0);
    check("midrst_tima_data", 16'(tif.O_TIMA_DATA),  16'h00);
    check("midrst_tima_wr",   16'(tif.O_TIMA_WR_EN), 16'h0);
    check("midrst_irq",       16'(tif.O_TIMER_IRQ),  16'h0);
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b1;
    count_pulses(8, wr_cnt, irq_cnt);
    check("post_rst_no_irq", 16'(irq_cnt), 16'd0);
    check("post_rst_no_wr",  16'(wr_cnt),  16'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
